// File: rtl/mult16_seq_ctrl.sv
// Purpose: 16x16 unsigned multiply sequenced over one shared 8x8 multiplier, four byte-pair steps.
// Latency: 5 cycles from accept to out_valid (1 cycle when a zero operand is skipped).
// Backpressure: one job at a time; in_ready low until the product is taken, product held while out_ready is low.
module mult16_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  step;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [31:0] acc;
    logic [31:0] pp_shifted;

    // Align the current 8x8 partial product to its byte weight for this step.
    always_comb begin
        pp_shifted = {16'd0, mul_p};
        case (step)
            2'd0:    pp_shifted = {16'd0, mul_p};
            2'd1,
            2'd2:    pp_shifted = {8'd0, mul_p, 8'd0};
            default: pp_shifted = {mul_p, 16'd0};
        endcase
    end

    // Controller: state, step counter, accumulator and all outputs registered together.
    // mul_a/mul_b are loaded one cycle ahead so they present the operands of the step being executed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            op_a      <= 16'd0;
            op_b      <= 16'd0;
            acc       <= 32'd0;
            mul_a     <= 8'd0;
            mul_b     <= 8'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b;
                        acc      <= 32'd0;
                        step     <= 2'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (SKIP_ZERO && (a == 16'd0 || b == 16'd0)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MUL;
                            mul_a <= a[7:0];
                            mul_b <= b[7:0];
                        end
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                    case (step)
                        2'd0: begin
                            mul_a <= op_a[15:8];
                            mul_b <= op_b[7:0];
                        end
                        2'd1: begin
                            mul_a <= op_a[7:0];
                            mul_b <= op_b[15:8];
                        end
                        2'd2: begin
                            mul_a <= op_a[15:8];
                            mul_b <= op_b[15:8];
                        end
                        default: begin
                            mul_a     <= 8'd0;
                            mul_b     <= 8'd0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    endcase
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mul_a     <= 8'd0;
                    mul_b     <= 8'd0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign product = acc;

endmodule

// File: tb/tb_mult16_seq_ctrl.sv
// Purpose: directed bench for mult16_seq_ctrl, with a behavioural 8x8 multiplier on mul_a/mul_b.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: out_ready is driven per scenario to exercise product hold.
module tb_mult16_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    // second instance with zero skipping disabled
    logic        nz_in_valid;
    logic        nz_in_ready;
    logic [15:0] nz_a;
    logic [15:0] nz_b;
    logic [7:0]  nz_mul_a;
    logic [7:0]  nz_mul_b;
    logic [15:0] nz_mul_p;
    logic        nz_out_valid;
    logic        nz_out_ready;
    logic [31:0] nz_product;
    logic        nz_busy;

    int vectors;
    int miscompares;

    mult16_seq_ctrl #(.SKIP_ZERO(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    mult16_seq_ctrl #(.SKIP_ZERO(1'b0)) dut_nz (
        .clk(clk), .rst_n(rst_n), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
        .a(nz_a), .b(nz_b), .mul_a(nz_mul_a), .mul_b(nz_mul_b), .mul_p(nz_mul_p),
        .out_valid(nz_out_valid), .out_ready(nz_out_ready), .product(nz_product), .busy(nz_busy)
    );

    assign mul_p    = 16'(mul_a * mul_b);
    assign nz_mul_p = 16'(nz_mul_a * nz_mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for one edge, then scramble the inputs.
    task automatic accept(input logic [15:0] va, input logic [15:0] vb);
        in_valid = 1'b1;
        a = va;
        b = vb;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL accept_in_ready: got %b want 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
    endtask

    // Wait for out_valid; lat = edges since accept (1 = already valid right after accept).
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
            miscompares++;
        end
        vectors++;
        if (product !== 32'd0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
            $display("FAIL reset_data: got product=%h mul_a=%h mul_b=%h want 0 0 0",
                     product, mul_a, mul_b);
            miscompares++;
        end
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        accept(16'h1234, 16'h5678);
        wait_valid(lat);
        vectors++;
        if (lat !== 5) begin
            $display("FAIL basic_latency: got %0d want 5", lat);
            miscompares++;
        end
        vectors++;
        if (product !== 32'h06260060) begin
            $display("FAIL basic_product: got %h want 06260060", product);
            miscompares++;
        end
        tick();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL basic_return: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
            miscompares++;
        end
    endtask

    task automatic test_steps();
        logic [15:0] exp_ops [0:5];
        exp_ops[0] = 16'h0000;
        exp_ops[1] = 16'hCD34;
        exp_ops[2] = 16'hAB34;
        exp_ops[3] = 16'hCD12;
        exp_ops[4] = 16'hAB12;
        exp_ops[5] = 16'h0000;
        out_ready = 1'b0;
        vectors++;
        if ({mul_a, mul_b} !== exp_ops[0]) begin
            $display("FAIL steps_idle: got %h want %h", {mul_a, mul_b}, exp_ops[0]);
            miscompares++;
        end
        accept(16'hABCD, 16'h1234);
        for (int i = 1; i <= 5; i++) begin
            vectors++;
            if ({mul_a, mul_b} !== exp_ops[i]) begin
                $display("FAIL steps_cycle%0d: got %h want %h", i, {mul_a, mul_b}, exp_ops[i]);
                miscompares++;
            end
            vectors++;
            if (busy !== 1'b1) begin
                $display("FAIL steps_busy%0d: got %b want 1", i, busy);
                miscompares++;
            end
            if (i < 5) tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || product !== 32'h0C374FA4) begin
            $display("FAIL steps_product: got valid=%b product=%h want 1 0C374FA4", out_valid, product);
            miscompares++;
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_max();
        int lat;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'hFFFF);
        wait_valid(lat);
        vectors++;
        if (lat !== 5 || product !== 32'hFFFE0001) begin
            $display("FAIL max_product: got lat=%0d product=%h want 5 FFFE0001", lat, product);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_zero_skip();
        int lat;
        logic mul_seen;
        out_ready = 1'b0;
        accept(16'h0000, 16'hABCD);
        mul_seen = (mul_a !== 8'd0) || (mul_b !== 8'd0);
        wait_valid(lat);
        vectors++;
        if (lat !== 1 || product !== 32'd0) begin
            $display("FAIL zskip_result: got lat=%0d product=%h want 1 0", lat, product);
            miscompares++;
        end
        vectors++;
        if (mul_seen || mul_a !== 8'd0 || mul_b !== 8'd0) begin
            $display("FAIL zskip_mul_ports: got mul_a=%h mul_b=%h nonzero_seen=%b want 0 0 0",
                     mul_a, mul_b, mul_seen);
            miscompares++;
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL zskip_return: got in_ready=%b want 1", in_ready);
            miscompares++;
        end
    endtask

    task automatic test_no_skip();
        int lat;
        nz_out_ready = 1'b1;
        nz_in_valid = 1'b1;
        nz_a = 16'h0000;
        nz_b = 16'hABCD;
        tick();
        nz_in_valid = 1'b0;
        lat = 1;
        while (nz_out_valid !== 1'b1 && lat < 30) begin
            tick();
            lat++;
        end
        vectors++;
        if (lat !== 5 || nz_product !== 32'd0) begin
            $display("FAIL noskip_result: got lat=%0d product=%h want 5 0", lat, nz_product);
            miscompares++;
        end
        tick();
        vectors++;
        if (nz_in_ready !== 1'b1 || nz_out_valid !== 1'b0) begin
            $display("FAIL noskip_return: got in_ready=%b out_valid=%b want 1 0",
                     nz_in_ready, nz_out_valid);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        accept(16'h00FF, 16'h0101);
        in_valid = 1'b1;
        a = 16'h0007;
        b = 16'h0009;
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || product !== 32'h0000FFFF || in_ready !== 1'b0) begin
                $display("FAIL bp_hold%0d: got valid=%b product=%h in_ready=%b want 1 0000FFFF 0",
                         i, out_valid, product, in_ready);
                miscompares++;
            end
            tick();
        end
        out_ready = 1'b1;
        vectors++;
        if (out_valid !== 1'b1 || product !== 32'h0000FFFF) begin
            $display("FAIL bp_last: got valid=%b product=%h want 1 0000FFFF", out_valid, product);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL bp_handshake: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        int lat;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'hFFFF);
        tick();
        tick();
        vectors++;
        if ({mul_a, mul_b} !== 16'hFFFF) begin
            $display("FAIL rstmid_step2: got %h want FFFF", {mul_a, mul_b});
            miscompares++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || product !== 32'd0 || in_ready !== 1'b1 || busy !== 1'b0 ||
            mul_a !== 8'd0 || mul_b !== 8'd0) begin
            $display("FAIL rstmid_state: got valid=%b product=%h in_ready=%b busy=%b mul=%h want 0 0 1 0 0",
                     out_valid, product, in_ready, busy, {mul_a, mul_b});
            miscompares++;
        end
        accept(16'd3, 16'd5);
        wait_valid(lat);
        vectors++;
        if (lat !== 5 || product !== 32'h0000000F) begin
            $display("FAIL rstmid_next: got lat=%0d product=%h want 5 0000000F", lat, product);
            miscompares++;
        end
        tick();
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a            = 16'd0;
        b            = 16'd0;
        nz_in_valid  = 1'b0;
        nz_out_ready = 1'b1;
        nz_a         = 16'd0;
        nz_b         = 16'd0;
        test_reset();
        test_basic();
        test_steps();
        test_max();
        test_zero_skip();
        test_no_skip();
        test_backpressure();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
